rtype_encoder: RTL and testbench
================================

# rtype_encoder

Encodes add/sub operation requests into 32-bit RV32I R-type instruction words and streams them into instruction memory at consecutive word addresses. It is the inverse of the instruction decoder: a program loader or test sequencer drives field-level requests in, and the instruction memory write port receives encoded words. It has one input handshake, one registered output stage with memory backpressure, a write-address counter and a capacity limit.

## Interface
- BASE_ADDR, 0: byte address of the first instruction word; must be 4-aligned.
- DEPTH, 16: maximum number of words written before the block reports full.
- ADDR_WIDTH, 32: width of mem_addr.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- clear  in  1  single-cycle pulse; restarts the write address and count without a full reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block accepts a request this cycle.
- in_op  in  2  operation: 0 = add, 1 = sub, 2 and 3 are illegal.
- in_rd, in_rs1, in_rs2  in  5 each  register indices.
- mem_valid  out  1  encoded word valid on the write port.
- mem_ready  in  1  memory accepts the word this cycle.
- mem_addr  out  ADDR_WIDTH  byte address of the word.
- mem_wdata  out  32  encoded instruction.
- count  out  $clog2(DEPTH+1)  words accepted by memory since reset or clear.
- full  out  1  count == DEPTH.
- err  out  1  one-cycle pulse after an illegal op is consumed.

## Operation
- Encoding: {funct7, rs2, rs1, 3'b000, rd, 7'b0110011}.
  - funct7 = 7'b0000000 for add.
  - funct7 = 7'b0100000 for sub.
- Accept: a request is consumed on a cycle with in_valid && in_ready.
- in_ready = !rst && !full && !pending_full && (!mem_valid || mem_ready).
  - pending_full means count + mem_valid == DEPTH.
  - The block never holds more words than the remaining capacity.
- Legal op consumed:
  - The output register loads the encoded word.
  - mem_addr loads BASE_ADDR + 4*widx, where widx is the next word index.
  - mem_valid is set to 1.
  - widx increments.
- Illegal op consumed:
  - No word is produced and widx is unchanged.
  - err pulses high on the next cycle.
  - If the consumed cycle also drained the output (mem_ready), mem_valid clears.
- Drain: when mem_valid && mem_ready and nothing new is loaded, mem_valid clears and count increments.
  - A simultaneous drain and load is allowed: count increments and the new word loads in the same cycle.
- Output stability: mem_addr and mem_wdata are held stable while mem_valid && !mem_ready.
- State machine:
  - EMPTY (mem_valid = 0), HOLD (mem_valid = 1), FULL (count == DEPTH).
  - EMPTY → HOLD on a legal accept.
  - HOLD → EMPTY on a drain without a load.
  - HOLD → HOLD on a drain with a load, or on a stall.
  - Any state → FULL when the drain makes count reach DEPTH.
  - FULL → EMPTY only on clear or rst.
- clear:
  - widx, count and full go to 0, and mem_valid drops.
  - Any held word is discarded: it is not written and not counted.
  - A request presented in the same cycle is not accepted, because in_ready is 0 during clear.
- Reset values: mem_valid 0, mem_addr BASE_ADDR, mem_wdata 0, count 0, full 0, err 0, in_ready 0 during the reset cycle.

## Timing
- Latency: request accept at edge N gives mem_valid = 1 after edge N, so the word is visible in cycle N+1.
- Throughput: one word per cycle when mem_ready is held at 1.
- count and full update on the edge where the final drain occurs.
- full asserts in the cycle after the DEPTH-th drain.
- in_ready is combinational from the registered state and mem_ready.
  - It has no path from in_valid or the in_* fields.
- rst mid-stream: at the next edge all state returns to reset values and the pending word is dropped.
- Simultaneous clear and mem_ready: clear wins, and count stays 0.

## Test plan
- Single add, mem_ready = 1: op=0, rd=5, rs1=2, rs2=3 → mem_wdata = 0x003102B3 at mem_addr = BASE_ADDR, with count = 1 one cycle later.
- Single sub: op=1, rd=10, rs1=4, rs2=5 → mem_wdata = 0x40520533 at the next word address (BASE_ADDR + 4).
- Backpressure: hold mem_ready = 0 for 3 cycles with in_valid = 1 →
  - in_ready = 0 throughout;
  - mem_addr and mem_wdata stay stable;
  - exactly one word is written after mem_ready rises.
- Capacity, DEPTH = 4: stream 6 legal requests with mem_ready = 1 →
  - 4 writes to BASE_ADDR, +4, +8, +12;
  - full = 1 and count = 4;
  - the 5th and 6th requests are never accepted.
- Illegal op = 2 between two adds →
  - err pulses once;
  - the two adds land at consecutive addresses;
  - count = 2.
- clear while a word is held with mem_ready = 0 → the word is dropped, count = 0, and the next add is written at BASE_ADDR.

Source files
------------

// File: rtl/rtype_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : rtype_encoder
//  Purpose  : Encodes add/sub requests into RV32I R-type words and streams
//             them to instruction memory at consecutive word addresses.
//  Revision : 1.0  initial release
// ============================================================================
module rtype_encoder #(
    parameter int BASE_ADDR  = 0,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [1:0]                   in_op,
    input  logic [4:0]                   in_rd,
    input  logic [4:0]                   in_rs1,
    input  logic [4:0]                   in_rs2,
    output logic                         mem_valid,
    input  logic                         mem_ready,
    output logic [ADDR_WIDTH-1:0]        mem_addr,
    output logic [31:0]                  mem_wdata,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         err
);

    localparam int c_CW = $clog2(DEPTH+1);

    localparam logic [1:0] c_S_EMPTY = 2'd0;
    localparam logic [1:0] c_S_HOLD  = 2'd1;
    localparam logic [1:0] c_S_FULL  = 2'd2;

    logic [1:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [31:0]           r_mem_wdata;
    logic [c_CW-1:0]       r_count;
    logic [c_CW-1:0]       r_widx;
    logic                  r_err;

    logic                  w_mem_valid;
    logic [c_CW:0]         w_fill;
    logic                  w_pending_full;
    logic                  w_accept;
    logic                  w_legal;
    logic                  w_drain;
    logic [c_CW-1:0]       w_count_inc;
    logic [31:0]           w_word;
    logic [ADDR_WIDTH-1:0] w_addr;

    assign w_mem_valid = (r_state == c_S_HOLD);

    // Words already counted plus the one in flight must stay within capacity.
    assign w_fill         = {1'b0, r_count} + {{c_CW{1'b0}}, w_mem_valid};
    assign w_pending_full = (w_fill == (c_CW+1)'(DEPTH));

    assign in_ready = !rst && !clear && (r_state != c_S_FULL) && !w_pending_full &&
                      (!w_mem_valid || mem_ready);

    assign w_accept    = in_valid && in_ready;
    assign w_legal     = !in_op[1];
    assign w_drain     = w_mem_valid && mem_ready;
    assign w_count_inc = r_count + c_CW'(1);

    assign w_word = {(in_op[0] ? 7'b0100000 : 7'b0000000), in_rs2, in_rs1, 3'b000,
                     in_rd, 7'b0110011};
    assign w_addr = ADDR_WIDTH'(BASE_ADDR) + (ADDR_WIDTH'(r_widx) << 2);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_S_EMPTY;
            r_mem_addr  <= ADDR_WIDTH'(BASE_ADDR);
            r_mem_wdata <= 32'd0;
            r_count     <= '0;
            r_widx      <= '0;
            r_err       <= 1'b0;
        end else if (clear) begin
            r_state <= c_S_EMPTY;
            r_count <= '0;
            r_widx  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= w_accept && !w_legal;
            if (w_drain) begin
                r_count <= w_count_inc;
            end
            if (w_accept && w_legal) begin
                r_mem_wdata <= w_word;
                r_mem_addr  <= w_addr;
                r_widx      <= r_widx + c_CW'(1);
            end
            // A drain that reaches capacity wins; no load can coincide with it.
            if (w_drain && (w_count_inc == c_CW'(DEPTH))) begin
                r_state <= c_S_FULL;
            end else if (w_accept && w_legal) begin
                r_state <= c_S_HOLD;
            end else if (w_drain) begin
                r_state <= c_S_EMPTY;
            end
        end
    end

    assign mem_valid = w_mem_valid;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign count     = r_count;
    assign full      = (r_state == c_S_FULL);
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_rtype_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rtype_encoder
//  Purpose  : Self-checking bench for rtype_encoder (DEPTH 4, non-zero base).
//  Revision : 1.0  initial release
// ============================================================================
module tb_rtype_encoder;

    localparam int c_BASE  = 'h100;
    localparam int c_DEPTH = 4;
    localparam int c_AW    = 16;
    localparam int c_CW    = $clog2(c_DEPTH+1);

    logic              clk = 1'b0;
    logic              rst, clear, in_valid, in_ready, mem_valid, mem_ready, full, err;
    logic [1:0]        in_op;
    logic [4:0]        in_rd, in_rs1, in_rs2;
    logic [c_AW-1:0]   mem_addr;
    logic [31:0]       mem_wdata;
    logic [c_CW-1:0]   count;

    always #5 clk = ~clk;

    rtype_encoder #(.BASE_ADDR(c_BASE), .DEPTH(c_DEPTH), .ADDR_WIDTH(c_AW)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .count(count), .full(full), .err(err)
    );

    typedef struct {
        logic [1:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] word;
        logic        acc;
    } vec_t;

    typedef struct {
        logic [c_AW-1:0] addr;
        logic [31:0]     data;
    } wr_t;

    vec_t vecs[6];
    wr_t  sb[$];

    int checks = 0, failures = 0, writes = 0, w0 = 0;

    // Reference model state
    logic            m_valid = 1'b0;
    logic [c_AW-1:0] m_addr  = c_AW'(c_BASE);
    logic [31:0]     m_data  = 32'd0;
    int              m_count = 0, m_widx = 0;
    logic            m_full  = 1'b0, m_err = 1'b0;

    logic acc_o, rdy_o;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic [1:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] word,
                        input logic mr, input logic clr, input logic r,
                        output logic acc, output logic rdy);
        logic m_rdy, do_wr, drain;
        wr_t  got, e;
        in_valid = v; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        mem_ready = mr; clear = clr; rst = r;
        #1;
        m_rdy = !r && !clr && !m_full && ((m_count + int'(m_valid)) != c_DEPTH) &&
                (!m_valid || mr);
        chk("in_ready", 32'(in_ready), 32'(m_rdy));
        chk("mem_valid", 32'(mem_valid), 32'(m_valid));
        chk("count", 32'(count), 32'(m_count));
        chk("full", 32'(full), 32'(m_full));
        chk("err", 32'(err), 32'(m_err));
        if (m_valid) begin
            chk("mem_addr", 32'(mem_addr), 32'(m_addr));
            chk("mem_wdata", mem_wdata, m_data);
        end
        rdy = in_ready;
        do_wr = mem_valid && mr && !clr && !r;
        got.addr = mem_addr;
        got.data = mem_wdata;
        acc = v && m_rdy;
        @(posedge clk);
        if (do_wr) begin
            writes++;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write: got addr %h data %h expected none",
                         got.addr, got.data);
            end else begin
                e = sb.pop_front();
                if (got.addr !== e.addr || got.data !== e.data) begin
                    failures++;
                    $display("FAIL sb_write: got %h/%h expected %h/%h",
                             got.addr, got.data, e.addr, e.data);
                end
            end
        end
        if (r) begin
            m_valid = 0; m_addr = c_AW'(c_BASE); m_data = 0;
            m_count = 0; m_widx = 0; m_full = 0; m_err = 0;
            sb.delete();
        end else if (clr) begin
            m_valid = 0; m_count = 0; m_widx = 0; m_full = 0; m_err = 0;
            sb.delete();
        end else begin
            drain = m_valid && mr;
            m_err = acc && op[1];
            if (drain) begin
                m_count++;
                if (m_count == c_DEPTH) m_full = 1'b1;
            end
            if (acc && !op[1]) begin
                m_addr  = c_AW'(c_BASE + 4 * m_widx);
                m_data  = word;
                m_valid = 1'b1;
                m_widx++;
                sb.push_back('{addr: m_addr, data: word});
            end else if (drain) begin
                m_valid = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic req(input logic [1:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] word, input logic mr);
        logic a, b;
        step(1'b1, op, rd, rs1, rs2, word, mr, 1'b0, 1'b0, a, b);
    endtask

    task automatic idle(input logic mr, input logic clr, input logic r);
        logic a, b;
        step(1'b0, 2'd0, 5'd0, 5'd0, 5'd0, 32'd0, mr, clr, r, a, b);
    endtask

    initial begin
        vecs[0] = '{op: 2'd0, rd: 5'd5,  rs1: 5'd2,  rs2: 5'd3,  word: 32'h003102B3, acc: 1'b1};
        vecs[1] = '{op: 2'd1, rd: 5'd10, rs1: 5'd4,  rs2: 5'd5,  word: 32'h40520533, acc: 1'b1};
        vecs[2] = '{op: 2'd0, rd: 5'd0,  rs1: 5'd0,  rs2: 5'd0,  word: 32'h00000033, acc: 1'b1};
        vecs[3] = '{op: 2'd1, rd: 5'd31, rs1: 5'd31, rs2: 5'd31, word: 32'h41FF8FB3, acc: 1'b1};
        vecs[4] = '{op: 2'd0, rd: 5'd3,  rs1: 5'd4,  rs2: 5'd5,  word: 32'h005201B3, acc: 1'b0};
        vecs[5] = '{op: 2'd1, rd: 5'd7,  rs1: 5'd8,  rs2: 5'd9,  word: 32'h409403B3, acc: 1'b0};

        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_op = 2'd0;
        in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0; mem_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        idle(1'b1, 1'b0, 1'b1);
        chk("rst_addr", 32'(mem_addr), 32'(c_BASE));
        chk("rst_wdata", mem_wdata, 32'd0);

        // Encoding table streamed back-to-back into a DEPTH-4 memory
        for (int i = 0; i < 6; i++) begin
            step(1'b1, vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].word,
                 1'b1, 1'b0, 1'b0, acc_o, rdy_o);
            chk($sformatf("vec%0d_accept", i), 32'(rdy_o), 32'(vecs[i].acc));
        end
        idle(1'b1, 1'b0, 1'b0);
        idle(1'b1, 1'b0, 1'b0);
        chk("cap_writes", writes, 4);
        chk("cap_full", 32'(full), 32'd1);
        chk("cap_count", 32'(count), 32'd4);

        // Backpressure: held word stays stable, one write on release
        idle(1'b0, 1'b1, 1'b0);
        w0 = writes;
        req(2'd0, 5'd5, 5'd2, 5'd3, 32'h003102B3, 1'b0);
        for (int i = 0; i < 3; i++) req(2'd0, 5'd1, 5'd2, 5'd3, 32'h003100B3, 1'b0);
        idle(1'b1, 1'b0, 1'b0);
        idle(1'b1, 1'b0, 1'b0);
        chk("bp_writes", writes - w0, 1);

        // Illegal op between two adds
        idle(1'b0, 1'b1, 1'b0);
        w0 = writes;
        req(2'd0, 5'd5, 5'd2, 5'd3, 32'h003102B3, 1'b1);
        req(2'd2, 5'd9, 5'd9, 5'd9, 32'd0, 1'b1);
        req(2'd0, 5'd1, 5'd2, 5'd3, 32'h003100B3, 1'b1);
        idle(1'b1, 1'b0, 1'b0);
        idle(1'b1, 1'b0, 1'b0);
        chk("ill_writes", writes - w0, 2);
        chk("ill_count", 32'(count), 32'd2);

        // clear drops a held word
        idle(1'b0, 1'b1, 1'b0);
        w0 = writes;
        req(2'd1, 5'd10, 5'd4, 5'd5, 32'h40520533, 1'b0);
        idle(1'b0, 1'b0, 1'b0);
        step(1'b1, 2'd0, 5'd1, 5'd2, 5'd3, 32'h003100B3, 1'b0, 1'b1, 1'b0, acc_o, rdy_o);
        chk("clr_count", 32'(count), 32'd0);
        req(2'd0, 5'd5, 5'd2, 5'd3, 32'h003102B3, 1'b1);
        chk("clr_addr", 32'(mem_addr), 32'(c_BASE));
        idle(1'b1, 1'b0, 1'b0);
        chk("clr_writes", writes - w0, 1);

        // clear wins over a simultaneous drain
        w0 = writes;
        req(2'd0, 5'd1, 5'd2, 5'd3, 32'h003100B3, 1'b0);
        idle(1'b1, 1'b1, 1'b0);
        chk("clrdrain_count", 32'(count), 32'd0);
        idle(1'b1, 1'b0, 1'b0);
        chk("clrdrain_writes", writes - w0, 0);

        // rst mid-stream drops the pending word
        req(2'd1, 5'd31, 5'd31, 5'd31, 32'h41FF8FB3, 1'b0);
        idle(1'b1, 1'b0, 1'b1);
        chk("rst2_addr", 32'(mem_addr), 32'(c_BASE));
        chk("rst2_wdata", mem_wdata, 32'd0);
        idle(1'b1, 1'b0, 1'b0);

        chk("sb_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
